// File: rtl/ex_mem_skid_if.sv
// EX->MEM handshake bundle: EX-side request fields and MEM-side head fields.
// The stage itself takes the slave view; the producer/consumer side takes master.
interface ex_mem_skid_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  instr;
    logic [WIDTH-1:0]  PC;
    logic [WIDTH-1:0]  ALU_Result;
    logic [WIDTH-1:0]  store_data;
    logic [CTRL_W-1:0] ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  instr_o;
    logic [WIDTH-1:0]  PC_o;
    logic [WIDTH-1:0]  ALU_Result_o;
    logic [WIDTH-1:0]  store_data_o;
    logic [CTRL_W-1:0] ctrl_o;

    modport master (
        output in_valid, instr, PC, ALU_Result, store_data, ctrl, out_ready,
        input  in_ready, out_valid, instr_o, PC_o, ALU_Result_o, store_data_o, ctrl_o
    );

    modport slave (
        input  in_valid, instr, PC, ALU_Result, store_data, ctrl, out_ready,
        output in_ready, out_valid, instr_o, PC_o, ALU_Result_o, store_data_o, ctrl_o
    );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a 2-entry skid buffer, flush-to-bubble and a
// saturating stall-cycle counter. All outputs come straight from registers.
//
//   state | meaning
//   EMPTY | no entry held (hv=0, sv=0)
//   ONE   | head valid, skid empty (hv=1, sv=0)
//   FULL  | head and skid valid (hv=1, sv=1); in_ready low
module ex_mem_skid_reg #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    ex_mem_skid_if.slave     bus,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic [WIDTH-1:0]  instr;
        logic [WIDTH-1:0]  pc;
        logic [WIDTH-1:0]  alu;
        logic [WIDTH-1:0]  sd;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t head_q, skid_q, in_entry;
    logic   hv, sv, accept, pop;
    logic   load_h_in, load_h_skid, load_s_in;

    assign hv       = (state_q == ONE) || (state_q == FULL);
    assign sv       = (state_q == FULL);
    assign accept   = bus.in_valid && !sv && !flush;
    assign pop      = hv && bus.out_ready;
    assign in_entry = {bus.instr, bus.PC, bus.ALU_Result, bus.store_data, bus.ctrl};

    always_comb begin
        state_d     = state_q;
        load_h_in   = 1'b0;
        load_h_skid = 1'b0;
        load_s_in   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_h_in = 1'b1;
                end
            end
            ONE: begin
                if (pop && accept) begin
                    load_h_in = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    state_d   = FULL;
                    load_s_in = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d     = ONE;
                    load_h_skid = !flush;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush turns everything into a bubble; a same-cycle pop is still consumed.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            head_q    <= '0;
            skid_q    <= '0;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (load_h_in) begin
                head_q <= in_entry;
            end else if (load_h_skid) begin
                head_q <= skid_q;
            end
            if (load_s_in) begin
                skid_q <= in_entry;
            end
            if (hv && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready     = !sv;
    assign bus.out_valid    = hv;
    assign bus.instr_o      = head_q.instr;
    assign bus.PC_o         = head_q.pc;
    assign bus.ALU_Result_o = head_q.alu;
    assign bus.store_data_o = head_q.sd;
    assign bus.ctrl_o       = hv ? head_q.ctrl : '0;
endmodule
